event_ctr_sched: RTL and testbench
==================================

# event_ctr_sched

Scheduler that shares one WIDTH-bit incrementer among a bank of NUM_CTRS event counters, for the core's hardware performance-monitoring unit. Each event source gets a small saturating pending accumulator. A round-robin arbiter picks one non-empty accumulator per cycle and folds its pending amount into that source's architectural counter through the single shared adder. The CSR unit reads counters combinationally and can clear any counter.

## Interface
- NUM_CTRS, 4, number of event sources and counters (power of two, ≥2)
- WIDTH, 32, architectural counter width
- PEND_W, 3, pending accumulator width; saturates at 2^PEND_W−1
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- event_in  input  NUM_CTRS  per-source event pulse, at most one event per source per cycle
- rd_idx  input  log2(NUM_CTRS)  counter select for read
- rd_data  output  WIDTH  ctr[rd_idx], combinational from registers
- clr_valid  input  1  clear request this cycle
- clr_idx  input  log2(NUM_CTRS)  counter to clear
- pend_sat  output  NUM_CTRS  bit i high while pend[i] is at maximum
- busy  output  1  OR of (pend[i] != 0)
- ovf  output  NUM_CTRS  sticky wrap flags; present only with EVENT_CTR_SCHED_OVF_EN

## Operation
- State: ctr[NUM_CTRS][WIDTH], pend[NUM_CTRS][PEND_W], rr_ptr[log2 N], and ovf[N] when configured.
- Reset: all ctr=0, pend=0, rr_ptr=0, ovf=0. Outputs therefore reset to rd_data=0, pend_sat=0, busy=0, ovf=0.
- Request: req[i] = (pend[i] != 0).
- Arbitration:
  - Grant g is the first i with req[i]=1, scanning from rr_ptr upward modulo NUM_CTRS.
  - With no requests, there is no grant and rr_ptr holds.
  - On a grant, rr_ptr ← (g+1) mod NUM_CTRS.
- Commit on grant: ctr[g] ← ctr[g] + zero_extend(pend[g]), modulo 2^WIDTH, computed by the single shared adder.
- Pending update, each i:
  - granted: pend[i] ← event_in[i] (0 or 1)
  - otherwise: pend[i] ← pend[i] + event_in[i]
- Pending saturation: when pend[i] = 2^PEND_W−1 and the source is not granted, a new event is dropped and pend holds.
- Clear (clr_valid=1, index c):
  - ctr[c] ← 0, pend[c] ← event_in[c], ovf[c] ← 0.
  - Clear wins over a same-cycle grant to c. The grant is still consumed: rr_ptr advances past c and the adder result is discarded.
  - Other indices are unaffected.
- Reset mid-operation: synchronous rst discards all pending events and in-flight commits. The cycle after rst deasserts behaves as fresh.

## Timing
- Event accepted in cycle t → pend visible at t+1 → earliest grant at t+1 → ctr updated at the t+2 edge and visible on rd_data in cycle t+2.
- Worst-case commit latency for a non-saturated source is NUM_CTRS cycles after its pend becomes non-zero.
- Sustained throughput: one counter commit per cycle.
- A source events every cycle under full contention: it accumulates at most NUM_CTRS per round, so PEND_W ≥ log2(NUM_CTRS)+1 is required to avoid drops. Parameter check at elaboration.
- rd_data and pend_sat are combinational from state; there is no read latency. A read in the same cycle as a commit returns the pre-commit value.
- Clear takes effect at the next edge; rd_data of that index reads 0 from the next cycle.

## Configuration
- EVENT_CTR_SCHED_OVF_EN defined:
  - adder carry-out on a commit to g sets ovf[g]=1 (sticky)
  - ovf[g] is cleared only by clr or rst
  - clear beats set in the same cycle
  - ovf port present
- Undefined: no ovf state and no ovf port. Counters wrap silently.

## Structure
- Package event_ctr_pkg:
  - IDX_W function of NUM_CTRS
  - localparam PEND_MAX
  - typedef for the grant struct {valid, idx}
- Sub-module rr_arbiter #(N): inputs req[N] and ptr; outputs gnt_valid and gnt_idx; purely combinational priority rotate.
- The shared increment uses one instance of the team's adder #(WIDTH). No per-counter adders.
- Registers use the team's register module, with the reset adapted to sync active-high.

## Test plan
- Single event on source 2 at cycle 5 → pend[2]=1 at 6, grant at 6, rd_data(idx 2)=1 from cycle 7; busy high only in cycle 6.
- All 4 sources event every cycle for 20 cycles, PEND_W=3:
  - grants rotate in order 0,1,2,3,…
  - no pend_sat
  - after draining, each ctr=20
- Source 1 events every cycle while rst held for 3 cycles → all ctr=0 and pend=0 after rst deasserts.
- Preload ctr[0]=2^32−2 via events, then 3 more events → ctr[0] wraps to 1; with OVF_EN, ovf[0]=1 and stays set until clr_valid idx 0.
- clr_valid idx 3 in the same cycle ctr[3] is granted and event_in[3]=1 → ctr[3]=0, pend[3]=1, then ctr[3]=1 two cycles later; rr_ptr advances to 0.
- PEND_W=2 with sources 0–3 eventing continuously → pend_sat asserts on starved sources; events during saturation are not counted; final counts match the model.

Source files
------------

// File: rtl/event_ctr_pkg.sv
// rtl/event_ctr_pkg.sv - shared types and sizing helpers for the event counter scheduler
package event_ctr_pkg;
   localparam int NUM_CTRS_DEF = 4;
   localparam int WIDTH_DEF    = 32;
   localparam int PEND_W_DEF   = 3;
   localparam int PEND_MAX     = (1 << PEND_W_DEF) - 1;
   localparam int GNT_IDX_W    = 8;

   typedef struct packed {
      logic                 valid;
      logic [GNT_IDX_W-1:0] idx;
   } grant_t;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/adder.sv
// rtl/adder.sv - plain W-bit adder with carry out
module adder #(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum,
   output logic         cout
);
   assign {cout, sum} = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/register.sv
// rtl/register.sv - enabled register with synchronous active-high reset
module register #(
   parameter int           W       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk) begin
      if (rst)
         q <= RST_VAL;
      else if (en)
         q <= d;
   end
endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at ptr (N power of two)
module rr_arbiter
   import event_ctr_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]            req,
   input  logic [$clog2(N)-1:0]    ptr,
   output logic                    gnt_valid,
   output logic [$clog2(N)-1:0]    gnt_idx
);
   localparam int IW = idx_w(N);

   logic [IW-1:0] cand;

   // Scan from the farthest offset down so the nearest requester after ptr wins.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int k = N - 1; k >= 0; k--) begin
         cand = ptr + IW'(k);
         if (req[cand]) begin
            gnt_valid = 1'b1;
            gnt_idx   = cand;
         end
      end
   end
endmodule

// File: rtl/event_ctr_sched.sv
// rtl/event_ctr_sched.sv - event counter bank sharing one adder via round-robin commit
// Optional sticky wrap flags: EVENT_CTR_SCHED_OVF_EN
module event_ctr_sched
   import event_ctr_pkg::*;
#(
   parameter int NUM_CTRS        = NUM_CTRS_DEF,
   parameter int WIDTH           = WIDTH_DEF,
   parameter int PEND_W          = PEND_W_DEF,
   parameter bit ALLOW_PEND_DROP = 1'b0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_CTRS-1:0]         event_in,
   input  logic [$clog2(NUM_CTRS)-1:0] rd_idx,
   output logic [WIDTH-1:0]            rd_data,
   input  logic                        clr_valid,
   input  logic [$clog2(NUM_CTRS)-1:0] clr_idx,
   output logic [NUM_CTRS-1:0]         pend_sat,
   output logic                        busy
`ifdef EVENT_CTR_SCHED_OVF_EN
   ,
   output logic [NUM_CTRS-1:0]         ovf
`endif
);
   localparam int IW = idx_w(NUM_CTRS);
   localparam logic [PEND_W-1:0] PEND_FULL = '1;

   if (NUM_CTRS < 2 || (1 << $clog2(NUM_CTRS)) != NUM_CTRS) begin : g_bad_num
      $error("event_ctr_sched: NUM_CTRS must be a power of two >= 2");
   end
   // A source eventing every cycle gathers up to NUM_CTRS per round.
   if (!ALLOW_PEND_DROP && PEND_W < $clog2(NUM_CTRS) + 1) begin : g_bad_pend
      $error("event_ctr_sched: PEND_W too small, events would be dropped");
   end

   logic [WIDTH-1:0]  ctr_q  [NUM_CTRS];
   logic [PEND_W-1:0] pend_q [NUM_CTRS];
   logic [IW-1:0]     rr_ptr_q;
   logic [NUM_CTRS-1:0] req;
   logic              gnt_valid;
   logic [IW-1:0]     gnt_idx;
   grant_t            gnt;
   logic [WIDTH-1:0]  sum;
   logic              carry;

   rr_arbiter #(.N(NUM_CTRS)) u_arb (
      .req       (req),
      .ptr       (rr_ptr_q),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   assign gnt = '{valid: gnt_valid, idx: GNT_IDX_W'(gnt_idx)};

   adder #(.W(WIDTH)) u_add (
      .a    (ctr_q[gnt_idx]),
      .b    (WIDTH'(pend_q[gnt_idx])),
      .sum  (sum),
      .cout (carry)
   );

`ifndef EVENT_CTR_SCHED_OVF_EN
   logic carry_unused;
   assign carry_unused = carry;
`endif

   register #(.W(IW)) u_rr_ptr (
      .clk (clk),
      .rst (rst),
      .en  (gnt.valid),
      .d   (gnt_idx + IW'(1)),
      .q   (rr_ptr_q)
   );

   for (genvar i = 0; i < NUM_CTRS; i++) begin : g_ctr
      logic              granted;
      logic              cleared;
      logic [WIDTH-1:0]  ctr_d;
      logic [PEND_W-1:0] pend_d;

      assign granted = gnt.valid && (gnt.idx == GNT_IDX_W'(i));
      assign cleared = clr_valid && (clr_idx == IW'(i));
      // Clear overrides the commit; the adder result for this slot is dropped.
      assign ctr_d   = cleared ? '0 : sum;

      always_comb begin
         pend_d = pend_q[i];
         if (cleared || granted)
            pend_d = PEND_W'(event_in[i]);
         else if (pend_q[i] != PEND_FULL)
            pend_d = pend_q[i] + PEND_W'(event_in[i]);
      end

      register #(.W(WIDTH)) u_ctr (
         .clk (clk),
         .rst (rst),
         .en  (cleared || granted),
         .d   (ctr_d),
         .q   (ctr_q[i])
      );

      register #(.W(PEND_W)) u_pend (
         .clk (clk),
         .rst (rst),
         .en  (1'b1),
         .d   (pend_d),
         .q   (pend_q[i])
      );

`ifdef EVENT_CTR_SCHED_OVF_EN
      register #(.W(1)) u_ovf (
         .clk (clk),
         .rst (rst),
         .en  (cleared || (granted && carry)),
         .d   (!cleared),
         .q   (ovf[i])
      );
`endif

      assign req[i]      = (pend_q[i] != '0);
      assign pend_sat[i] = (pend_q[i] == PEND_FULL);
   end

   assign busy    = |req;
   assign rd_data = ctr_q[rd_idx];
endmodule

// File: tb/tb_event_ctr_sched.sv
// tb/tb_event_ctr_sched.sv - directed self-checking bench for event_ctr_sched
module tb_event_ctr_sched;
   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] event_in;
   logic [1:0] rd_idx;
   logic       clr_valid;
   logic [1:0] clr_idx;
   logic [31:0] rd_data;
   logic [4:0]  rd_data_s;
   logic [3:0]  pend_sat, pend_sat_s;
   logic        busy, busy_s;
`ifdef EVENT_CTR_SCHED_OVF_EN
   logic [3:0]  ovf, ovf_s;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   logic [3:0] sat_seen;

   always #5 clk = ~clk;

   event_ctr_sched u_dut (
      .clk       (clk),
      .rst       (rst),
      .event_in  (event_in),
      .rd_idx    (rd_idx),
      .rd_data   (rd_data),
      .clr_valid (clr_valid),
      .clr_idx   (clr_idx),
      .pend_sat  (pend_sat),
      .busy      (busy)
`ifdef EVENT_CTR_SCHED_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   // Narrow, drop-tolerant instance: saturation and wrap are reachable quickly.
   event_ctr_sched #(.NUM_CTRS(4), .WIDTH(5), .PEND_W(2), .ALLOW_PEND_DROP(1'b1)) u_sat (
      .clk       (clk),
      .rst       (rst),
      .event_in  (event_in),
      .rd_idx    (rd_idx),
      .rd_data   (rd_data_s),
      .clr_valid (clr_valid),
      .clr_idx   (clr_idx),
      .pend_sat  (pend_sat_s),
      .busy      (busy_s)
`ifdef EVENT_CTR_SCHED_OVF_EN
      ,
      .ovf       (ovf_s)
`endif
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic read(input int idx);
      rd_idx = 2'(idx);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int exp_rot   [4] = '{1, 2, 3, 4};
      int exp_rot_s [4] = '{1, 2, 3, 3};
      int exp_fin_s [4] = '{16, 16, 16, 15};

      rst = 1'b1; event_in = '0; rd_idx = '0; clr_valid = 1'b0; clr_idx = '0;
      sat_seen = '0;
      step(); step();

      check_eq("reset_rd_data", rd_data, 0);
      check_eq("reset_pend_sat", pend_sat, 0);
      check_eq("reset_busy", busy, 0);
      check_eq("reset_busy_s", busy_s, 0);
`ifdef EVENT_CTR_SCHED_OVF_EN
      check_eq("reset_ovf", ovf, 0);
`endif

      // Single event on source 2
      rst = 1'b0;
      event_in = 4'b0100;
      read(2);
      check_eq("single_busy_t0", busy, 0);
      step();
      event_in = '0;
      #1;
      check_eq("single_busy_t1", busy, 1);
      check_eq("single_precommit", rd_data, 0);
      step();
      check_eq("single_rd_t2", rd_data, 1);
      check_eq("single_busy_t2", busy, 0);

      // All four sources every cycle for 20 cycles, then drain
      rst = 1'b1; step(); rst = 1'b0;
      for (int k = 0; k < 30; k++) begin
         event_in = (k < 20) ? 4'hF : 4'h0;
         if (k >= 2 && k <= 5) begin
            read(k - 2);
            check_eq($sformatf("rot_ctr%0d", k - 2), rd_data, exp_rot[k-2]);
            check_eq($sformatf("rot_sat_ctr%0d", k - 2), rd_data_s, exp_rot_s[k-2]);
         end
         if (k == 4)
            check_eq("pend_sat_pattern", pend_sat_s, 4'b1001);
         sat_seen = sat_seen | pend_sat;
         step();
      end
      check_eq("no_pend_sat_w3", sat_seen, 0);
      check_eq("drain_busy", busy, 0);
      check_eq("drain_busy_s", busy_s, 0);
      for (int i = 0; i < 4; i++) begin
         read(i);
         check_eq($sformatf("full_ctr%0d", i), rd_data, 20);
         check_eq($sformatf("sat_ctr%0d", i), rd_data_s, exp_fin_s[i]);
      end

      // Source 1 eventing while reset is held for 3 cycles
      rst = 1'b1; event_in = 4'b0010;
      step(); step(); step();
      rst = 1'b0; event_in = 4'b0010;
      #1;
      check_eq("rst_hold_busy", busy, 0);
      for (int i = 0; i < 4; i++) begin
         read(i);
         check_eq($sformatf("rst_hold_ctr%0d", i), rd_data, 0);
      end

      // Clear colliding with a grant to source 3 (rr_ptr at 2 beforehand)
      step();
      event_in = '0;
      #1;
      check_eq("fresh_busy", busy, 1);
      step();
      event_in = 4'b1000;
      read(1);
      check_eq("fresh_ctr1", rd_data, 1);
      step();
      event_in = 4'b1001; clr_valid = 1'b1; clr_idx = 2'd3;
      step();
      event_in = '0; clr_valid = 1'b0;
      read(3);
      check_eq("clr_ctr3_after", rd_data, 0);
      check_eq("clr_busy_pend", busy, 1);
      step();
      read(3);
      check_eq("clr_ptr_ctr3", rd_data, 0);
      read(0);
      check_eq("clr_ptr_ctr0", rd_data, 1);
      step();
      read(3);
      check_eq("clr_ctr3_final", rd_data, 1);
      check_eq("clr_ctr3_final_s", rd_data_s, 1);
      check_eq("clr_busy_end", busy, 0);

      // Wrap on source 0 (u_sat is 5 bits wide)
      rst = 1'b1; step(); rst = 1'b0;
      event_in = 4'b0001;
      repeat (30) step();
      event_in = '0;
      repeat (3) step();
      read(0);
      check_eq("wrap_pre", rd_data, 30);
      check_eq("wrap_pre_s", rd_data_s, 30);
`ifdef EVENT_CTR_SCHED_OVF_EN
      check_eq("wrap_pre_ovf_s", ovf_s, 0);
`endif
      event_in = 4'b0001;
      repeat (3) step();
      event_in = '0;
      repeat (3) step();
      check_eq("wrap_post", rd_data, 33);
      check_eq("wrap_post_s", rd_data_s, 1);
`ifdef EVENT_CTR_SCHED_OVF_EN
      check_eq("wrap_ovf_s", ovf_s, 4'b0001);
      check_eq("wrap_ovf_wide", ovf, 0);
      step();
      check_eq("wrap_ovf_sticky", ovf_s, 4'b0001);
`endif
      clr_valid = 1'b1; clr_idx = 2'd0;
      step();
      clr_valid = 1'b0;
      #1;
      check_eq("wrap_clr_s", rd_data_s, 0);
      check_eq("wrap_clr", rd_data, 0);
`ifdef EVENT_CTR_SCHED_OVF_EN
      check_eq("wrap_clr_ovf_s", ovf_s, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
